// File: rtl/uart_pkg.sv
// Shared UART definitions: TX sequencer state type and ASCII control constants.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage for uart_tx_fifo: simple dual-port RAM, synchronous write, asynchronous read.
module uart_tx_fifo_mem #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [7:0]            rd_data
);

  logic [7:0] mem_q [2**DEPTH_LOG2];

  // Storage array is not reset; occupancy tracking in the parent makes stale data unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer feeding the uart wrapper TX side (tx_wr / tx_flag handshake).
// Optional build macro UART_TX_FIFO_CRLF_EN: send CR ahead of every LF.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          wr_data,
  input  logic                wr_en,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
  output logic [7:0]          tx_data,
  output logic                tx_wr,
  input  logic                tx_flag
);

  localparam int unsigned        Depth     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0] CountOne  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  tx_state_e             state_q, state_d;
  logic                  tx_wr_q, tx_wr_d;
  logic [7:0]            tx_data_q, tx_data_d;
`ifdef UART_TX_FIFO_CRLF_EN
  logic                  cr_sent_q, cr_sent_d;
`endif

  logic       push;
  logic       pop;
  logic [7:0] head;

  // Flags decode the registered occupancy only, so wr_en never reaches them combinationally.
  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

  // A write is accepted only against the registered full flag; a same-cycle pop does not help.
  assign push = wr_en && !full;

  uart_tx_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_addr(rd_ptr_q),
    .rd_data(head)
  );

  // Pointer, occupancy and sticky overflow next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    if (push && !pop) begin
      count_d = count_q + CountOne;
    end else if (pop && !push) begin
      count_d = count_q - CountOne;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  // Sequencer: IDLE launches one byte when the wrapper is idle, BUSY waits for it to finish.
  always_comb begin
    state_d   = state_q;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
    cr_sent_d = cr_sent_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty && tx_flag) begin
          tx_wr_d = 1'b1;
          state_d = BUSY;
`ifdef UART_TX_FIFO_CRLF_EN
          // LF stays at the head while its CR goes out; the next launch sends and pops it.
          if (head == ASCII_LF && !cr_sent_q) begin
            tx_data_d = ASCII_CR;
            cr_sent_d = 1'b1;
          end else begin
            tx_data_d = head;
            pop       = 1'b1;
            cr_sent_d = 1'b0;
          end
`else
          tx_data_d = head;
          pop       = 1'b1;
`endif
        end
      end
      BUSY: begin
        if (tx_flag) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // All state, reset synchronously.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= 8'h00;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_q  <= cr_sent_d;
`endif
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_wr    = tx_wr_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural uart wrapper and byte-stream scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        full, empty, overflow, tx_wr, tx_flag;
  logic [DL:0] count;
  logic [7:0]  tx_data;

  int checks = 0;
  int errors = 0;

  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  int   sends = 0;
  logic hold = 1'b0;
  logic flag_m = 1'b1;
  int   busy_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH_LOG2(DL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .tx_flag (tx_flag)
  );

  // Wrapper model: goes busy for FRAME cycles after each tx_wr; hold forces it to look busy.
  assign tx_flag = flag_m && !hold;

  always @(posedge clk) begin
    if (reset) begin
      flag_m   <= 1'b1;
      busy_cnt <= 0;
    end else if (tx_wr) begin
      flag_m   <= 1'b0;
      busy_cnt <= FRAME;
      got_q.push_back(tx_data);
      sends++;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) flag_m <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected wire stream for one accepted byte.
  task automatic push_exp(input byte unsigned b);
`ifdef UART_TX_FIFO_CRLF_EN
    if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(b);
  endtask

  task automatic wr(input byte unsigned b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    step();
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((got_q.size() < exp_q.size() || !empty || tx_wr) && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  byte unsigned rb;
  int s0, s1;

  initial begin
    // Reset state
    step();
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_wr", tx_wr, 0);
    chk("rst_tx_data", tx_data, 8'h00);

    // Single byte: tx_wr exactly two cycles after the write
    wr_en   = 1'b1;
    wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    chk("single_count", count, 1);
    chk("single_empty", empty, 0);
    chk("single_txwr_early", tx_wr, 0);
    step();
    chk("single_txwr", tx_wr, 1);
    chk("single_txdata", tx_data, 8'h41);
    chk("single_empty_after", empty, 1);
    step();
    chk("single_txwr_pulse", tx_wr, 0);
    chk("single_txdata_hold", tx_data, 8'h41);
    push_exp(8'h41);
    drain("single_order");

    // Burst of 16 with the wrapper held busy, then released
    hold = 1'b1;
    s0   = sends;
    for (int i = 0; i < DEPTH; i++) begin
      wr(byte'(i));
      push_exp(byte'(i));
    end
    chk("burst_full", full, 1);
    chk("burst_count", count, DEPTH);
    s1   = exp_q.size();
    hold = 1'b0;
    drain("burst_order");
    chk("burst_pulses", sends - s0, s1);

    // Overflow: write while full is dropped and sticky until reset
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (rb == 8'h0A) rb = 8'h5A;
      wr(rb);
    end
    chk("ovf_pre", overflow, 0);
    wr(8'hFF);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, DEPTH);
    chk("ovf_full", full, 1);
    repeat (3) step();
    chk("ovf_sticky", overflow, 1);
    hold = 1'b0;
    do_reset();
    chk("ovf_clear", overflow, 0);
    chk("ovf_rst_count", count, 0);
    chk("ovf_rst_empty", empty, 1);

    // Simultaneous push and pop at count 5, then random traffic wrapping the pointers
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rb = 8'(8'h20 + i);
      wr(rb);
      push_exp(rb);
    end
    chk("pp_count_pre", count, 5);
    hold    = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    push_exp(8'h77);
    chk("pp_count", count, 5);
    chk("pp_txwr", tx_wr, 1);
    chk("pp_txdata", tx_data, 8'h20);
    for (int c = 0; c < 250; c++) begin
      if ($urandom_range(0, 1) == 1 && (exp_q.size() - got_q.size()) < DEPTH - 1) begin
        rb = 8'($urandom_range(0, 255));
        if (rb == 8'h0A) rb = 8'hA0;
        wr(rb);
        push_exp(rb);
      end else begin
        step();
      end
    end
    drain("wrap_order");
    chk("wrap_empty", empty, 1);
    chk("wrap_count", count, 0);
    chk("wrap_overflow", overflow, 0);

    // Line feed: CR inserted ahead of it when the CRLF build is selected
    repeat (FRAME + 2) step();
    s0 = sends;
    wr(8'h0A);
    push_exp(8'h0A);
    s1 = exp_q.size();
    drain("lf_seq");
    chk("lf_pulses", sends - s0, s1);

    // Reset while BUSY with 3 bytes queued
    repeat (FRAME + 2) step();
    s0 = sends;
    for (int i = 0; i < 4; i++) wr(byte'(8'h51 + i));
    for (int n = 0; n < 20 && sends == s0; n++) step();
    chk("rb_first_sent", sends - s0, 1);
    step();
    chk("rb_count_pre", count, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rb_count", count, 0);
    chk("rb_txwr", tx_wr, 0);
    chk("rb_empty", empty, 1);
    s1 = sends;
    repeat (40) step();
    chk("rb_no_sends", sends - s1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
